// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack data-memory responder: address map,
// region decode and the screen-update record carried to the display side.
package hack_mem_pkg;

  localparam logic [14:0] SCREEN_BASE  = 15'h4000;
  localparam logic [14:0] KBD_ADDR     = 15'h6000;
  localparam int          SCREEN_WORDS = 8192;
  localparam int          RAM_WORDS    = 16384;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SCREEN,
    REG_KBD,
    REG_NONE
  } mem_region_e;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } scr_update_t;

  // Classify a CPU data address into the region that serves it
  function automatic mem_region_e decode_region(input logic [14:0] addr);
    if (addr < SCREEN_BASE) begin
      return REG_RAM;
    end else if (addr < KBD_ADDR) begin
      return REG_SCREEN;
    end else if (addr == KBD_ADDR) begin
      return REG_KBD;
    end else begin
      return REG_NONE;
    end
  endfunction

endpackage

// File: rtl/hack_sync_fifo.sv
// Small synchronous FIFO with wrap-around pointers one bit wider than the
// index so full and empty are told apart without a separate counter.
// The caller decides when push/pop are legal; this block just obeys them.
module hack_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  // Advance each pointer by one on an accepted push or pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; a push into a full FIFO alongside a pop reuses the head slot,
  // which is safe because the head was already presented this cycle
  always_ff @(posedge clock) begin
    if (push && !reset) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/hack_data_memory.sv
// Hack CPU data-memory responder: RAM, memory-mapped screen and keyboard.
// Screen writes are also forwarded to the display over a valid/ready queue.
// Build option HACK_MEM_KBD_FIFO_EN: when defined the keyboard is a
// KBD_DEPTH-entry FIFO acknowledged by writing 0x6000; otherwise it is a
// single holding register that always shows the most recent key code.
module hack_data_memory
  import hack_mem_pkg::*;
#(
  parameter int KBD_DEPTH = 4,
  parameter int SCR_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_code,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_valid,
  input  logic        scr_ready,
  output logic        scr_overflow
);

  if (SCR_DEPTH < 2 || (SCR_DEPTH & (SCR_DEPTH - 1)) != 0) begin : g_bad_scr_depth
    $error("SCR_DEPTH must be a power of two and at least 2");
  end
  if (KBD_DEPTH < 2 || (KBD_DEPTH & (KBD_DEPTH - 1)) != 0) begin : g_bad_kbd_depth
    $error("KBD_DEPTH must be a power of two and at least 2");
  end

  mem_region_e region;
  logic [15:0] mem_q [RAM_WORDS + SCREEN_WORDS];
  logic        mem_we;
  logic [15:0] kbd_value;

  assign region = decode_region(addressM);
  assign mem_we = writeM && (region == REG_RAM || region == REG_SCREEN);

  // RAM and screen share one word array indexed directly by the address
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[addressM] <= outM;
  end

  // ---------------- screen update queue ----------------
  scr_update_t scr_entry, scr_head;
  logic        scr_write, scr_push, scr_pop, scr_full, scr_empty;
  logic        scr_overflow_q, scr_overflow_d;

  // The screen base is 8K aligned, so the word offset is just the low 13 bits
  assign scr_entry = '{addr: addressM[12:0], data: outM};
  assign scr_write = writeM && (region == REG_SCREEN);
  assign scr_pop   = !scr_empty && scr_ready;
  assign scr_push  = scr_write && (!scr_full || scr_pop);

  hack_sync_fifo #(
    .WIDTH($bits(scr_update_t)),
    .DEPTH(SCR_DEPTH)
  ) u_scr_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (scr_push),
    .pop      (scr_pop),
    .push_data(scr_entry),
    .head     (scr_head),
    .full     (scr_full),
    .empty    (scr_empty)
  );

  assign scr_valid = !scr_empty;
  assign scr_addr  = scr_head.addr;
  assign scr_data  = scr_head.data;

  // Overflow latches when a screen write finds the queue full with no room freed
  always_comb begin
    scr_overflow_d = scr_overflow_q | (scr_write && scr_full && !scr_pop);
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) scr_overflow_q <= 1'b0;
    else       scr_overflow_q <= scr_overflow_d;
  end

  assign scr_overflow = scr_overflow_q;

  // ---------------- keyboard ----------------
`ifdef HACK_MEM_KBD_FIFO_EN
  logic        kbd_push, kbd_pop, kbd_full, kbd_empty;
  logic [15:0] kbd_head;

  assign kbd_ready = !kbd_full && !reset;
  assign kbd_push  = kbd_valid && kbd_ready;
  assign kbd_pop   = writeM && (region == REG_KBD) && !kbd_empty;

  hack_sync_fifo #(
    .WIDTH(16),
    .DEPTH(KBD_DEPTH)
  ) u_kbd_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (kbd_push),
    .pop      (kbd_pop),
    .push_data(kbd_code),
    .head     (kbd_head),
    .full     (kbd_full),
    .empty    (kbd_empty)
  );

  assign kbd_value = kbd_empty ? 16'h0000 : kbd_head;
`else
  logic [15:0] kbd_hold_q, kbd_hold_d;

  // Every offered key code replaces the held one
  always_comb begin
    kbd_hold_d = kbd_valid ? kbd_code : kbd_hold_q;
  end

  // Holding register for the latest key code
  always_ff @(posedge clock) begin
    if (reset) kbd_hold_q <= 16'h0000;
    else       kbd_hold_q <= kbd_hold_d;
  end

  assign kbd_ready = 1'b1;
  assign kbd_value = kbd_hold_q;
`endif

  // Zero-latency read mux so the CPU can sample inM within the same cycle
  always_comb begin
    inM = 16'h0000;
    case (region)
      REG_RAM, REG_SCREEN: inM = mem_q[addressM];
      REG_KBD:             inM = kbd_value;
      default:             inM = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_hack_data_memory.sv
// Self-checking bench for hack_data_memory: directed scenarios pinned with
// literal expectations, then randomized traffic checked every cycle against
// a queue/array model of the memory map, screen queue and keyboard.
module tb_hack_data_memory;

  localparam int KBD_DEPTH = 4;
  localparam int SCR_DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic [15:0] kbd_code;
  logic        kbd_valid;
  logic        kbd_ready;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_valid;
  logic        scr_ready;
  logic        scr_overflow;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [15:0] m_mem [int];
  int          m_scr_addr [$];
  int          m_scr_data [$];
  int          m_kbd [$];
  bit          m_ovf  = 1'b0;
  int          m_hold = 0;

  hack_data_memory #(
    .KBD_DEPTH(KBD_DEPTH),
    .SCR_DEPTH(SCR_DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .addressM    (addressM),
    .outM        (outM),
    .writeM      (writeM),
    .inM         (inM),
    .kbd_code    (kbd_code),
    .kbd_valid   (kbd_valid),
    .kbd_ready   (kbd_ready),
    .scr_addr    (scr_addr),
    .scr_data    (scr_data),
    .scr_valid   (scr_valid),
    .scr_ready   (scr_ready),
    .scr_overflow(scr_overflow)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge and wait to mid-cycle
  task automatic applyStimulus(input bit rst, input bit wm, input int addr, input int data,
                               input bit kv, input int kc, input bit sr);
    reset     = rst;
    writeM    = wm;
    addressM  = 15'(addr);
    outM      = 16'(data);
    kbd_valid = kv;
    kbd_code  = 16'(kc);
    scr_ready = sr;
    @(negedge clock);
  endtask

  // Compare every meaningful output against the model at mid-cycle
  task automatic checkOutput();
    int a;
    int kexp;
    a = int'(addressM);
`ifdef HACK_MEM_KBD_FIFO_EN
    kexp = (m_kbd.size() > 0) ? m_kbd[0] : 0;
    cmp("kbd_ready", int'(kbd_ready), (!reset && m_kbd.size() < KBD_DEPTH) ? 1 : 0);
`else
    kexp = m_hold;
    cmp("kbd_ready", int'(kbd_ready), 1);
`endif
    if (a < 'h6000) begin
      if (m_mem.exists(a)) cmp("inM_array", int'(inM), int'(m_mem[a]));
    end else if (a == 'h6000) begin
      cmp("inM_kbd", int'(inM), kexp);
    end else begin
      cmp("inM_unmapped", int'(inM), 0);
    end
    cmp("scr_valid", int'(scr_valid), (m_scr_addr.size() > 0) ? 1 : 0);
    if (m_scr_addr.size() > 0) begin
      cmp("scr_addr", int'(scr_addr), m_scr_addr[0]);
      cmp("scr_data", int'(scr_data), m_scr_data[0]);
    end
    cmp("scr_overflow", int'(scr_overflow), int'(m_ovf));
  endtask

  // Advance the model across the rising edge using the held inputs
  task automatic modelUpdate();
    int  a;
    bit  kbd_rdy;
    a = int'(addressM);
    if (writeM && a < 'h6000) m_mem[a] = outM;
    if (reset) begin
      m_scr_addr.delete();
      m_scr_data.delete();
      m_kbd.delete();
      m_ovf  = 1'b0;
      m_hold = 0;
    end else begin
      if (m_scr_addr.size() > 0 && scr_ready) begin
        void'(m_scr_addr.pop_front());
        void'(m_scr_data.pop_front());
      end
      if (writeM && a >= 'h4000 && a < 'h6000) begin
        if (m_scr_addr.size() < SCR_DEPTH) begin
          m_scr_addr.push_back(a - 'h4000);
          m_scr_data.push_back(int'(outM));
        end else begin
          m_ovf = 1'b1;
        end
      end
`ifdef HACK_MEM_KBD_FIFO_EN
      kbd_rdy = (m_kbd.size() < KBD_DEPTH);
      if (writeM && a == 'h6000 && m_kbd.size() > 0) void'(m_kbd.pop_front());
      if (kbd_valid && kbd_rdy) m_kbd.push_back(int'(kbd_code));
`else
      kbd_rdy = 1'b1;
      if (kbd_valid && kbd_rdy) m_hold = int'(kbd_code);
`endif
    end
  endtask

  task automatic tick();
    @(posedge clock);
    modelUpdate();
    #1;
  endtask

  task automatic step(input bit rst, input bit wm, input int addr, input int data,
                      input bit kv, input int kc, input bit sr);
    applyStimulus(rst, wm, addr, data, kv, kc, sr);
    checkOutput();
  endtask

  initial begin
    int r;
    int addr;

    // Power-up: first reset cycle is not checked, DUT state is undefined before it
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    step(1, 0, 'h6000, 0, 0, 0, 0);
    cmp("lit_reset_scr_valid", int'(scr_valid), 0);
    cmp("lit_reset_overflow", int'(scr_overflow), 0);
`ifdef HACK_MEM_KBD_FIFO_EN
    cmp("lit_reset_kbd_ready", int'(kbd_ready), 0);
`else
    cmp("lit_reset_kbd_ready", int'(kbd_ready), 1);
`endif
    tick();

    // RAM write then read back
    step(0, 1, 1000, 11111, 0, 0, 0); tick();
    step(0, 1, 'h3000, 'h5555, 0, 0, 0); tick();
    step(0, 0, 1000, 0, 0, 0, 0);
    cmp("lit_ram_read", int'(inM), 11111);
    cmp("lit_ram_no_scr", int'(scr_valid), 0);
    tick();

    // Screen forward held until ready
    step(0, 1, 'h4005, 'hAAAA, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 'h4005, 0, 0, 0, 0);
      cmp("lit_scr_hold_valid", int'(scr_valid), 1);
      cmp("lit_scr_hold_addr", int'(scr_addr), 5);
      cmp("lit_scr_hold_data", int'(scr_data), 'hAAAA);
      tick();
    end
    step(0, 0, 'h4005, 0, 0, 0, 1); tick();
    step(0, 0, 'h4005, 0, 0, 0, 0);
    cmp("lit_scr_drained", int'(scr_valid), 0);
    cmp("lit_scr_readback", int'(inM), 'hAAAA);
    tick();

    // Screen overflow: fifth write dropped, order kept
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 'h4010 + i, i + 1, 0, 0, 0); tick();
    end
    step(0, 0, 'h4014, 0, 0, 0, 0);
    cmp("lit_ovf_set", int'(scr_overflow), 1);
    cmp("lit_ovf_array_written", int'(inM), 5);
    tick();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      cmp("lit_drain_data", int'(scr_data), i + 1);
      cmp("lit_drain_addr", int'(scr_addr), 'h10 + i);
      tick();
    end
    step(0, 0, 0, 0, 0, 0, 0);
    cmp("lit_drain_empty", int'(scr_valid), 0);
    tick();

    // Keyboard
    step(0, 0, 'h6000, 0, 1, 65, 0); tick();
    step(0, 0, 'h6000, 0, 1, 66, 0); tick();
`ifdef HACK_MEM_KBD_FIFO_EN
    step(0, 0, 'h6000, 0, 0, 0, 0); cmp("lit_kbd_head65", int'(inM), 65); tick();
    step(0, 1, 'h6000, 0, 0, 0, 0); tick();
    step(0, 0, 'h6000, 0, 0, 0, 0); cmp("lit_kbd_head66", int'(inM), 66); tick();
    step(0, 1, 'h6000, 0, 0, 0, 0); tick();
    step(0, 0, 'h6000, 0, 0, 0, 0); cmp("lit_kbd_empty", int'(inM), 0); tick();
    step(0, 1, 'h6000, 0, 0, 0, 0); tick();
    step(0, 0, 'h6000, 0, 0, 0, 0); cmp("lit_kbd_empty_ack", int'(inM), 0); tick();
    for (int i = 0; i < KBD_DEPTH; i++) begin
      step(0, 0, 'h6000, 0, 1, 100 + i, 0); tick();
    end
    step(0, 0, 'h6000, 0, 0, 0, 0);
    cmp("lit_kbd_full_ready", int'(kbd_ready), 0);
    cmp("lit_kbd_full_head", int'(inM), 100);
    tick();
    for (int i = 0; i < KBD_DEPTH; i++) begin
      step(0, 1, 'h6000, 0, 0, 0, 0); tick();
    end
`else
    step(0, 0, 'h6000, 0, 0, 0, 0); cmp("lit_kbd_latest", int'(inM), 66); tick();
    step(0, 1, 'h6000, 0, 0, 0, 0); tick();
    step(0, 0, 'h6000, 0, 0, 0, 0);
    cmp("lit_kbd_write_ignored", int'(inM), 66);
    cmp("lit_kbd_ready_high", int'(kbd_ready), 1);
    tick();
`endif

    // Unmapped addresses
    step(0, 0, 'h6001, 0, 0, 0, 0); cmp("lit_unmapped_read", int'(inM), 0); tick();
    step(0, 1, 'h7000, 'h1234, 0, 0, 0); tick();
    step(0, 0, 'h7000, 0, 0, 0, 0);
    cmp("lit_unmapped_write", int'(inM), 0);
    cmp("lit_unmapped_no_scr", int'(scr_valid), 0);
    tick();
    step(0, 0, 'h3000, 0, 0, 0, 0); cmp("lit_no_alias", int'(inM), 'h5555); tick();

    // Reset mid-stream (overflow is still set from above)
    step(0, 1, 'h4100, 7, 1, 31, 0); tick();
    step(0, 1, 'h4101, 8, 1, 32, 0); tick();
    step(0, 0, 0, 0, 1, 33, 0); tick();
    step(1, 0, 'h6000, 0, 0, 0, 0); tick();
    step(0, 0, 'h6000, 0, 0, 0, 0);
    cmp("lit_rst_scr_valid", int'(scr_valid), 0);
    cmp("lit_rst_kbd", int'(inM), 0);
    cmp("lit_rst_overflow", int'(scr_overflow), 0);
    tick();
    step(0, 0, 1000, 0, 0, 0, 0); cmp("lit_rst_ram_kept", int'(inM), 11111); tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      addr = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 'h3FFF) : $urandom_range(0, 15);
      else if (r < 7) addr = 'h4000 + (($urandom_range(0, 7) == 0) ? $urandom_range(0, 'h1FFF) : $urandom_range(0, 15));
      else if (r < 9) addr = 'h6000;
      else            addr = 'h6001 + $urandom_range(0, 'h1FFE);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, addr, $urandom_range(0, 'hFFFF),
           $urandom_range(0, 2) == 0, $urandom_range(0, 'hFFFF), $urandom_range(0, 3) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hack_data_memory.md
Name: hack_data_memory

Overview:
- Data-memory responder on the CPU's M-port: serves inM for the CPU's addressM/outM/writeM.
- Maps RAM 0x0000–0x3FFF, screen 0x4000–0x5FFF and keyboard 0x6000.
- Forwards every screen write on an outbound valid/ready stream to the display side.
- Buffers inbound key codes from the keyboard side in a FIFO.

Parameters:
- KBD_DEPTH, 4, keyboard FIFO entries (power of 2, ≥2)
- SCR_DEPTH, 4, screen-update queue entries (power of 2, ≥2)

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- addressM  in  15  CPU data address
- outM  in  16  CPU write data
- writeM  in  1  CPU write strobe
- inM  out  16  read data to CPU
- kbd_code  in  16  key code from keyboard side (0 = release)
- kbd_valid  in  1  kbd_code valid
- kbd_ready  out  1  FIFO can accept
- scr_addr  out  13  screen word offset (addressM − 0x4000)
- scr_data  out  16  screen word written
- scr_valid  out  1  queue head valid
- scr_ready  in  1  display consumed head
- scr_overflow  out  1  sticky: a screen update was dropped

Behaviour:
- Reset (sync, active-high): both FIFOs emptied, scr_overflow=0, kbd_ready=0 while reset high, scr_valid=0. RAM/screen arrays are not cleared.
- Read path is combinational, zero latency; inM follows addressM in the same cycle, as the CPU samples inM mid-cycle.
  - 0x0000–0x5FFF: array word.
  - 0x6000: keyboard FIFO head, 0 if empty.
  - >0x6000: 0.
- Write path: when writeM=1 at the rising edge:
  - RAM/screen word updated; a read of the same address in the next cycle returns the new value.
  - Writes to >0x6000 are ignored.
- Screen forwarding: each screen-region write pushes {addressM−0x4000, outM} into the screen queue.
  - Queue full and no pop this cycle: entry dropped, array still written, scr_overflow←1 (cleared only by reset).
  - Full with a simultaneous pop (scr_valid & scr_ready): push accepted, no overflow.
- Screen output: scr_valid = !empty; head held stable until scr_ready. Order preserved.
- Keyboard side:
  - kbd_ready = !full && !reset, from registered state only.
  - Push on kbd_valid & kbd_ready.
  - A push into a full FIFO is not accepted even if a pop occurs in the same cycle.
- Keyboard acknowledge: a write (any data) to 0x6000 pops the keyboard FIFO if non-empty; no effect if empty.
  - Push and pop in one cycle on a non-empty FIFO: count unchanged.
  - Empty FIFO with a push and a write to 0x6000 in the same cycle: push accepted, pop ignored.
- Reset mid-operation: queued screen entries and key codes are lost; in-flight scr_valid drops the next cycle.
- Counters: wrap-around pointers with log2(depth)+1 bits; full = MSB differ, low bits equal.

Optional Feature:
- Macro HACK_MEM_KBD_FIFO_EN.
- Defined: keyboard behaviour as above, with a KBD_DEPTH-entry FIFO.
- Undefined: the keyboard is a single 16-bit holding register.
  - kbd_ready=1 always; every kbd_valid overwrites it.
  - A read of 0x6000 returns the latest code.
  - Writes to 0x6000 are ignored.
  - KBD_DEPTH unused.

Decomposition:
- Package hack_mem_pkg:
  - constants SCREEN_BASE=15'h4000, KBD_ADDR=15'h6000, SCREEN_WORDS=8192, RAM_WORDS=16384
  - enum mem_region_e {REG_RAM, REG_SCREEN, REG_KBD, REG_NONE}
  - struct scr_update_t {addr[12:0], data[15:0]}
  - function decode_region(addr)
- Sub-module hack_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/head), instantiated for the screen queue and for the keyboard FIFO.

Test Plan:
- RAM write/read: writeM=1, addressM=1000, outM=11111; next cycle addressM=1000, writeM=0 → inM=11111, scr_valid=0.
- Screen forward: write 0x4005 ← 0xAAAA with scr_ready=0 → scr_valid=1, scr_addr=5, scr_data=0xAAAA held for 3 cycles; scr_ready=1 → scr_valid=0 next cycle; read 0x4005 → 0xAAAA.
- Screen overflow: scr_ready=0, 5 screen writes (data 1..5) → first 4 queued, scr_overflow=1; drain returns 1,2,3,4 in order.
- Keyboard FIFO: push 65,66 → inM@0x6000=65; write 0x6000 → 66; write again → 0; with KBD_DEPTH pushes, kbd_ready=0.
- Unmapped address: read 0x6001 → 0; write 0x7000 ← 0x1234 → no array or queue change.
- Reset mid-stream: 2 queued screen entries and 3 key codes, reset=1 for 1 cycle → scr_valid=0, inM@0x6000=0, scr_overflow=0, RAM word 1000 still 11111.
